// File: rtl/tick_scheduler.sv
// Programmable game-tick scheduler: prescaled base tick, per-channel period
// counters, pending/overrun tracking and a round-robin valid/ready grant port.
module tick_scheduler #(
  parameter int PRESCALE = 50000,
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    pause,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic                    cfg_en,
  input  logic                    ovr_clr,
  output logic                    tick_valid,
  output logic [$clog2(N_CH)-1:0] tick_ch,
  input  logic                    tick_ready,
  output logic [N_CH-1:0]         overrun,
  output logic                    base_tick
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;

  logic [N_CH-1:0] pending_reg, pending_next;
  logic [N_CH-1:0] overrun_reg, overrun_next;
  logic [N_CH-1:0] expire;
  logic [N_CH-1:0] cfg_hit;
  logic [N_CH-1:0] grant;

  logic            tick_valid_reg, tick_valid_next;
  logic [CH_W-1:0] tick_ch_reg, tick_ch_next;
  logic [CH_W-1:0] last_reg, last_next;

  // Prescaler: holds while paused so the whole time base freezes together.
  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    if (!pause) begin
      pre_cnt_next = (pre_cnt_reg == PRE_LAST) ? '0 : pre_cnt_reg + PRE_W'(1);
    end
  end

  assign base_tick = (pre_cnt_reg == PRE_LAST) && !pause;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] period_reg, cnt_reg, cnt_next;
      logic             en_reg;
      logic             active;

      assign active      = en_reg && (period_reg != '0);
      assign cfg_hit[gi] = cfg_we && (cfg_ch == CH_W'(gi));
      assign expire[gi]  = base_tick && active && (cnt_reg == period_reg - CNT_W'(1));

      always_comb begin
        cnt_next = cnt_reg;
        if (cfg_hit[gi] || !active || expire[gi]) begin
          cnt_next = '0;
        end else if (base_tick) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      // A config write wins over everything; a grant and a fresh expiry in
      // the same cycle leave the channel pending for the new event.
      assign pending_next[gi] = cfg_hit[gi] ? 1'b0 :
                                expire[gi]  ? 1'b1 :
                                grant[gi]   ? 1'b0 : pending_reg[gi];

      assign overrun_next[gi] = cfg_hit[gi] ? 1'b0 :
                                (expire[gi] && pending_reg[gi] && !grant[gi]) ? 1'b1 :
                                ovr_clr     ? 1'b0 : overrun_reg[gi];

      always_ff @(posedge clk_in) begin
        if (reset) begin
          period_reg <= '0;
          en_reg     <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_next;
          if (cfg_hit[gi]) begin
            period_reg <= cfg_period;
            en_reg     <= cfg_en;
          end
        end
      end
    end
  endgenerate

  // Round-robin arbiter: search from last+1 upward with wrap.
  always_comb begin
    logic            slot_free;
    logic            found;
    logic [CH_W-1:0] sel;
    int              idx;

    slot_free       = !tick_valid_reg || tick_ready;
    found           = 1'b0;
    sel             = '0;
    idx             = 0;
    grant           = '0;
    tick_valid_next = tick_valid_reg;
    tick_ch_next    = tick_ch_reg;
    last_next       = last_reg;

    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_reg) + k) % N_CH;
      if (!found && pending_reg[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end

    if (slot_free) begin
      tick_valid_next = found;
      if (found) begin
        grant        = N_CH'(1) << sel;
        tick_ch_next = sel;
        last_next    = sel;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pending_reg    <= '0;
      overrun_reg    <= '0;
      tick_valid_reg <= 1'b0;
      tick_ch_reg    <= '0;
      last_reg       <= LAST_CH;
    end else begin
      pending_reg    <= pending_next;
      overrun_reg    <= overrun_next;
      tick_valid_reg <= tick_valid_next;
      tick_ch_reg    <= tick_ch_next;
      last_reg       <= last_next;
    end
  end

  assign tick_valid = tick_valid_reg;
  assign tick_ch    = tick_ch_reg;
  assign overrun    = overrun_reg;

endmodule
